// File: rtl/capture_reg_arbiter_if.sv
// Bus between the producer blocks and the shared capture/flag arbiter.
// Handshake: a requester holds req[i] high with its word stable on
// req_data; the arbiter samples req only while idle and answers with a
// one-cycle ack[i] pulse in the cycle temp_q is loaded. out_valid pulses
// one cycle later with the new out_flag/out_owner. Ack is not a ready:
// req must be dropped within HOLD_CYC+1 cycles of ack, or it counts as
// a new request when the arbiter returns to idle.
interface capture_reg_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 4
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        ack;
  logic [DATA_W-1:0]         temp_q;
  logic                      out_flag;
  logic                      out_valid;
  logic [IDW-1:0]            out_owner;
  logic                      busy;
  logic [1:0]                state;

  modport master (
    output req, req_data,
    input  ack, temp_q, out_flag, out_valid, out_owner, busy, state
  );

  modport slave (
    input  req, req_data,
    output ack, temp_q, out_flag, out_valid, out_owner, busy, state
  );
endinterface

// File: rtl/capture_reg_arbiter.sv
// Round-robin arbiter and sequencer for one shared capture register.
// One winner is loaded into temp_q, its bit 0 is published as out_flag,
// then the register is held for HOLD_CYC cycles before the next grant.
// The state encoding is exported on bus.state for debug/checkers.
module capture_reg_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 4,
  parameter int HOLD_CYC = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  capture_reg_arbiter_if.slave   bus
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW  = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FLAG = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state;
  logic [IDW-1:0]     last_grant;
  logic [CW-1:0]      cnt;
  logic [NUM_REQ-1:0] ack_r;
  logic [DATA_W-1:0]  temp_r;
  logic               flag_r;
  logic               valid_r;
  logic [IDW-1:0]     owner_r;

  logic [IDW-1:0]     winner;
  logic               found;
  int                 scan_idx;

  // Rotating priority search starting just after the last grant, with wrap.
  // Only the first set bit in search order is looked at, so later
  // requesters cannot disturb the chosen winner.
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    scan_idx = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = (int'(last_grant) + k) % NUM_REQ;
      if (!found && (bus.req[scan_idx] == 1'b1)) begin
        found  = 1'b1;
        winner = IDW'(scan_idx);
      end
    end
  end

  // Grant/flag/hold sequencer; every output is a register updated here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= IDW'(NUM_REQ - 1);
      cnt        <= '0;
      ack_r      <= '0;
      temp_r     <= '0;
      flag_r     <= 1'b0;
      valid_r    <= 1'b0;
      owner_r    <= '0;
    end else begin
      ack_r   <= '0;
      valid_r <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            temp_r     <= bus.req_data[int'(winner)*DATA_W +: DATA_W];
            ack_r      <= NUM_REQ'(1) << winner;
            owner_r    <= winner;
            last_grant <= winner;
            state      <= FLAG;
          end
        end
        FLAG: begin
          flag_r  <= temp_r[0];
          valid_r <= 1'b1;
          cnt     <= CW'(HOLD_CYC - 1);
          state   <= HOLD;
        end
        HOLD: begin
          if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ack       = ack_r;
  assign bus.temp_q    = temp_r;
  assign bus.out_flag  = flag_r;
  assign bus.out_valid = valid_r;
  assign bus.out_owner = owner_r;
  assign bus.busy      = (state != IDLE);
  assign bus.state     = state;
endmodule

// File: tb/tb_capture_reg_arbiter.sv
// Directed bench for capture_reg_arbiter. Expected grants {owner, word}
// are queued when a request is driven and popped when ack appears.
module tb_capture_reg_arbiter;
  localparam int NUM_REQ  = 4;
  localparam int DATA_W   = 4;
  localparam int HOLD_CYC = 2;
  localparam int IDW      = 2;
  localparam int W        = IDW + DATA_W;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;
  int   last_ack_cyc;
  logic [W-1:0] exp_q[$];

  capture_reg_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  capture_reg_arbiter #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .HOLD_CYC(HOLD_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_words(input logic [3:0] w0, input logic [3:0] w1,
                           input logic [3:0] w2, input logic [3:0] w3);
    bus.req_data = {w3, w2, w1, w0};
  endtask

  task automatic push_exp(input int idx, input logic [DATA_W-1:0] word);
    exp_q.push_back({IDW'(idx), word});
  endtask

  // Wait (bounded) for an ack pulse and compare it with the queue head.
  task automatic wait_ack(input string tag);
    int n;
    logic [W-1:0] e;
    logic [IDW-1:0] e_idx;
    logic [DATA_W-1:0] e_word;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.ack == '0 && n < 20);
    check({tag, "_ack_seen"}, 32'(bus.ack != '0), 32'd1);
    check({tag, "_queue_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
    if (bus.ack != '0 && exp_q.size() != 0) begin
      e      = exp_q.pop_front();
      e_idx  = e[W-1:DATA_W];
      e_word = e[DATA_W-1:0];
      check({tag, "_ack"}, 32'(bus.ack), 32'(1) << e_idx);
      check({tag, "_temp_q"}, 32'(bus.temp_q), 32'(e_word));
      check({tag, "_owner"}, 32'(bus.out_owner), 32'(e_idx));
      check({tag, "_busy"}, 32'(bus.busy), 32'd1);
      check({tag, "_valid_early"}, 32'(bus.out_valid), 32'd0);
    end
    last_ack_cyc = cyc;
  endtask

  // One cycle after ack: out_valid pulse with the flag of the loaded word.
  task automatic check_flag(input string tag, input int idx, input logic [DATA_W-1:0] word);
    @(negedge clk);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_out_flag"}, 32'(bus.out_flag), 32'(word[0]));
    check({tag, "_owner_flag"}, 32'(bus.out_owner), 32'(idx));
    check({tag, "_ack_cleared"}, 32'(bus.ack), 32'd0);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (bus.busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int prev;
    checks = 0;
    errors = 0;
    bus.req = '0;
    bus.req_data = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // reset state
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_temp_q", 32'(bus.temp_q), 32'd0);
    check("rst_flag", 32'(bus.out_flag), 32'd0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_owner", 32'(bus.out_owner), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // single request from requester 2, word B
    set_words(4'h0, 4'h0, 4'hB, 4'h0);
    bus.req = 4'b0100;
    push_exp(2, 4'hB);
    wait_ack("t2");
    check_flag("t2", 2, 4'hB);
    bus.req = '0;
    @(negedge clk);
    check("t2_hold_busy", 32'(bus.busy), 32'd1);
    check("t2_valid_pulse", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("t2_busy_done", 32'(bus.busy), 32'd0);
    check("t2_temp_held", 32'(bus.temp_q), 32'hB);
    check("t2_flag_held", 32'(bus.out_flag), 32'd1);

    // async reset between edges during HOLD
    set_words(4'h5, 4'h0, 4'h0, 4'h0);
    bus.req = 4'b0001;
    push_exp(0, 4'h5);
    wait_ack("t1");
    check_flag("t1", 0, 4'h5);
    bus.req = '0;
    check("t1_in_hold", 32'(bus.state), 32'd2);
    #2 rst = 1'b1;
    #1;
    check("t1_temp_q", 32'(bus.temp_q), 32'd0);
    check("t1_flag", 32'(bus.out_flag), 32'd0);
    check("t1_valid", 32'(bus.out_valid), 32'd0);
    check("t1_owner", 32'(bus.out_owner), 32'd0);
    check("t1_ack", 32'(bus.ack), 32'd0);
    check("t1_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // all four requesting: 0,1,2,3,0 every HOLD_CYC+2 cycles
    set_words(4'h1, 4'h2, 4'h3, 4'h4);
    bus.req = 4'b1111;
    push_exp(0, 4'h1);
    push_exp(1, 4'h2);
    push_exp(2, 4'h3);
    push_exp(3, 4'h4);
    push_exp(0, 4'h1);
    wait_ack("t3_g0");
    check_flag("t3_g0", 0, 4'h1);
    for (int g = 1; g < 5; g++) begin
      prev = last_ack_cyc;
      wait_ack($sformatf("t3_g%0d", g));
      check($sformatf("t3_spacing%0d", g), 32'(last_ack_cyc - prev), 32'(HOLD_CYC + 2));
      check_flag($sformatf("t3_g%0d", g), g % 4, 4'(g % 4 + 1));
    end
    bus.req = '0;
    wait_idle("t3");

    // last_grant=1, then 0011 -> 0 (search 2,3,0), then 1
    set_words(4'h6, 4'h9, 4'h0, 4'h0);
    bus.req = 4'b0010;
    push_exp(1, 4'h9);
    wait_ack("t4_setup");
    check_flag("t4_setup", 1, 4'h9);
    bus.req = '0;
    wait_idle("t4_setup");
    bus.req = 4'b0011;
    push_exp(0, 4'h6);
    push_exp(1, 4'h9);
    wait_ack("t4_a");
    check_flag("t4_a", 0, 4'h6);
    wait_ack("t4_b");
    check_flag("t4_b", 1, 4'h9);
    bus.req = '0;
    wait_idle("t4");

    // reset pulse in FLAG cycle aborts the transaction
    set_words(4'h0, 4'h0, 4'h7, 4'h9);
    bus.req = 4'b0100;
    push_exp(2, 4'h7);
    wait_ack("t5_pre");
    #1 rst = 1'b1;
    #1;
    check("t5_temp_q", 32'(bus.temp_q), 32'd0);
    check("t5_ack", 32'(bus.ack), 32'd0);
    bus.req = '0;
    @(negedge clk);
    check("t5_no_valid", 32'(bus.out_valid), 32'd0);
    check("t5_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    bus.req = 4'b1000;
    push_exp(3, 4'h9);
    wait_ack("t5_post");
    check_flag("t5_post", 3, 4'h9);
    bus.req = '0;
    wait_idle("t5");

    // req0 never dropped: re-granted every HOLD_CYC+2 cycles
    set_words(4'hA, 4'h0, 4'h0, 4'h0);
    bus.req = 4'b0001;
    push_exp(0, 4'hA);
    push_exp(0, 4'hA);
    push_exp(0, 4'hA);
    wait_ack("t6_g0");
    check_flag("t6_g0", 0, 4'hA);
    for (int g = 1; g < 3; g++) begin
      prev = last_ack_cyc;
      wait_ack($sformatf("t6_g%0d", g));
      check($sformatf("t6_spacing%0d", g), 32'(last_ack_cyc - prev), 32'(HOLD_CYC + 2));
      check_flag($sformatf("t6_g%0d", g), 0, 4'hA);
    end
    bus.req = '0;
    wait_idle("t6");

    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
